// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller.
// Buffers one word and paces a downstream parallel-to-serial shifter.
module uart_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  localparam int FRAME_BITS  = DATA_BITS + 2 + PARITY_EN
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] parallel_in,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_valid_q, buf_valid_d;
  logic                 accept;

  // Ready depends only on registered state; no path from tx_valid.
  assign tx_ready = !buf_valid_q;
  assign accept   = tx_valid && !buf_valid_q;

  // Frame image: start, data LSB-first, optional parity, stop.
  always_comb begin
    parallel_in = '0;
    parallel_in[FRAME_BITS-1] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      parallel_in[FRAME_BITS-2-i] = buf_data_q[i];
    end
    if (PARITY_EN != 0) begin
      parallel_in[1] = (PARITY_ODD != 0) ? ~^buf_data_q : ^buf_data_q;
    end
    parallel_in[0] = 1'b1;
  end

  // Bit pacing FSM: next state, counters and strobes.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    frame_done   = 1'b0;
    tx_busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (buf_valid_q) begin
          load_enable = 1'b1;
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        tx_busy = 1'b1;
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q < BIT_LAST) begin
            shift_enable = 1'b1;
            bit_cnt_d    = bit_cnt_q + 1'b1;
          end else begin
            frame_done = 1'b1;
            if (buf_valid_q) begin
              // Chain the next frame with no idle gap.
              load_enable = 1'b1;
              bit_cnt_d   = '0;
            end else begin
              // Shift in the idle fill so the line rests high.
              shift_enable = 1'b1;
              state_d      = IDLE;
            end
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-entry buffer: filled on accept, emptied by each load.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (load_enable) begin
      buf_valid_d = 1'b0;
    end else if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = tx_data;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-offset model plus directed checks.
// Serial line is reconstructed from a model of the downstream shifter.
module tb_uart_tx_ctrl;

  localparam int DB  = 8;
  localparam int CPB = 4;
  localparam int FB  = DB + 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          load_enable;
  logic          shift_enable;
  logic [FB-1:0] parallel_in;
  logic          tx_busy;
  logic          frame_done;

  logic [DB-1:0] o_data = '0;
  logic          o_valid = 1'b0;
  logic          o_ready, o_load, o_shift, o_busy, o_done;
  logic [FB-1:0] o_par;

  uart_tx_ctrl #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .load_enable(load_enable),
    .shift_enable(shift_enable),
    .parallel_in(parallel_in),
    .tx_busy(tx_busy),
    .frame_done(frame_done)
  );

  uart_tx_ctrl #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(1)
  ) u_odd (
    .clk(clk), .n_rst(n_rst),
    .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready),
    .load_enable(o_load),
    .shift_enable(o_shift),
    .parallel_in(o_par),
    .tx_busy(o_busy),
    .frame_done(o_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Bit j of a frame in transmit order.
  function automatic logic fbit(input logic [DB-1:0] w,
                                input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
    if (idx == DB + 1) return 1'($countones(w) % 2);
    return 1'b1;
  endfunction

  function automatic logic [FB-1:0] img(input logic [DB-1:0] w);
    logic [FB-1:0] r;
    for (int j = 0; j < FB; j++) r[FB-1-j] = fbit(w, j);
    return r;
  endfunction

  // Model state: buffer, current frame and its offset.
  bit            chk_en = 1'b0;
  bit            m_bv = 1'b0;
  logic [DB-1:0] m_bd = '0;
  logic [DB-1:0] m_cur = '0;
  bit            m_in = 1'b0;
  int            m_k = 0;
  logic [FB-1:0] sr = '1;
  logic          ser_cur = 1'b1;
  bit            e_term, e_last, e_load, e_shift, acc;
  logic          e_ser;

  always @(negedge clk) begin
    if (chk_en) begin
      e_term  = m_in && (m_k % CPB == CPB - 1);
      e_last  = m_in && (m_k == FB * CPB - 1);
      e_load  = m_bv && (!m_in || e_last);
      e_shift = e_term && !e_load;
      e_ser   = m_in ? fbit(m_cur, m_k / CPB) : 1'b1;
      chk("tx_ready", 32'(tx_ready), 32'(!m_bv));
      chk("tx_busy", 32'(tx_busy), 32'(m_in));
      chk("load_enable", 32'(load_enable), 32'(e_load));
      chk("shift_enable", 32'(shift_enable), 32'(e_shift));
      chk("frame_done", 32'(frame_done), 32'(e_last));
      chk("parallel_in", 32'(parallel_in), 32'(img(m_bd)));
      chk("serial_out", 32'(sr[FB-1]), 32'(e_ser));
    end
    ser_cur = sr[FB-1];
    if (!n_rst) begin
      m_bv = 1'b0; m_bd = '0; m_in = 1'b0;
      m_k = 0; sr = '1; chk_en = 1'b1;
    end else if (chk_en) begin
      if (load_enable) sr = parallel_in;
      else if (shift_enable) sr = {sr[FB-2:0], 1'b1};
      acc = tx_valid && !m_bv;
      if (e_load) begin
        m_cur = m_bd; m_in = 1'b1; m_k = 0; m_bv = 1'b0;
      end else if (m_in) begin
        if (e_last) m_in = 1'b0;
        else m_k++;
      end
      if (acc) begin
        m_bv = 1'b1; m_bd = tx_data;
      end
    end
  end

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic obs();
    @(negedge clk); #1;
  endtask

  // Called at a drive point; returns at the drive point after accept.
  task automatic send(input logic [DB-1:0] d);
    bit got;
    got = 1'b0;
    tx_data = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      obs();
      if (tx_ready) got = 1'b1;
      drv();
    end
    tx_valid = 1'b0;
    chk("send_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_load(input string nm, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      obs();
      if (load_enable) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 120 && !idle; i++) begin
      obs();
      if (!tx_busy && tx_ready) idle = 1'b1;
    end
    chk(nm, 32'(idle), 32'd1);
  endtask

  int            c_a, c_b, c_c, c_d, c_e;
  int            run, maxrun, didx;
  logic [FB-1:0] sbits, img1, img2;
  logic [DB-1:0] cap;
  bit            got, dsh, reached;

  initial begin
    // Reset, then idle
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    c_a = 0; c_b = 0;
    repeat (20) begin
      obs();
      c_a += int'(tx_ready);
      c_b += int'(load_enable | shift_enable | tx_busy | frame_done);
    end
    chk("idle_ready_cycles", 32'(c_a), 32'd20);
    chk("idle_activity", 32'(c_b), 32'd0);
    chk("reset_image", 32'(parallel_in), 32'h001);

    // Odd parity image
    chk("odd_ready", 32'(o_ready), 32'd1);
    drv();
    o_data = 8'hA5; o_valid = 1'b1;
    drv();
    o_valid = 1'b0;
    obs();
    chk("odd_load", 32'(o_load), 32'd1);
    chk("odd_image", 32'(o_par), 32'h297);
    chk("odd_quiet", 32'({o_shift, o_busy, o_done}), 32'd0);

    // Single frame 0xA5
    drv();
    send(8'hA5);
    wait_load("single_load", 10);
    chk("single_image", 32'(parallel_in), 32'h295);
    c_a = 0; c_b = 0; c_c = 0; c_d = 0;
    sbits = '0; didx = 0; dsh = 1'b0;
    for (int i = 0; i < FB * CPB; i++) begin
      obs();
      c_a += int'(shift_enable);
      c_b += int'(frame_done);
      c_c += int'(tx_busy);
      c_d += int'(load_enable);
      if (i % CPB == 1) sbits = {sbits[FB-2:0], ser_cur};
      if (frame_done) begin
        didx = c_a; dsh = shift_enable;
      end
    end
    chk("single_shifts", 32'(c_a), 32'd11);
    chk("single_done", 32'(c_b), 32'd1);
    chk("single_busy", 32'(c_c), 32'd44);
    chk("single_loads", 32'(c_d), 32'd0);
    chk("single_serial", 32'(sbits), 32'b01010010101);
    chk("done_on_11th", 32'({dsh, 4'(didx)}), 32'h1b);
    obs();
    chk("single_after", 32'(tx_busy), 32'd0);

    // Back-to-back 0x00 then 0xFF
    drv();
    tx_data = 8'h00; tx_valid = 1'b1;
    drv();
    tx_data = 8'hFF;
    c_a = 0; c_b = 0; run = 0; maxrun = 0;
    img1 = '0; img2 = '0;
    for (int i = 0; i < 100; i++) begin
      obs();
      if (load_enable) begin
        c_a++;
        if (c_a == 1) img1 = parallel_in;
        if (c_a == 2) begin
          img2 = parallel_in;
          chk("b2b_term_load",
              32'({shift_enable, frame_done, tx_busy}), 32'b011);
        end
      end
      c_b += int'(frame_done);
      run = tx_busy ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      drv();
      if (i == 1) tx_valid = 1'b0;
    end
    chk("b2b_loads", 32'(c_a), 32'd2);
    chk("b2b_done", 32'(c_b), 32'd2);
    chk("b2b_busy_run", 32'(maxrun), 32'd88);
    chk("b2b_image0", 32'(img1), 32'h001);
    chk("b2b_image1", 32'(img2), 32'h3FD);

    // Backpressure with changing data
    send(8'h11);
    send(8'h22);
    tx_valid = 1'b1;
    tx_data = 8'h40;
    c_a = 0; got = 1'b0; cap = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      obs();
      if (tx_ready) begin
        got = 1'b1; cap = tx_data;
      end else begin
        c_a++;
      end
      drv();
      if (got) tx_valid = 1'b0;
      else tx_data = 8'(8'h40 + i + 1);
    end
    chk("bp_ready_seen", 32'(got), 32'd1);
    chk("bp_held_cycles", 32'(c_a), 32'd43);
    chk("bp_captured", 32'(cap), 32'h6B);
    wait_load("bp_load", 60);
    chk("bp_image", 32'(parallel_in), 32'h35B);
    wait_idle("bp_idle");

    // Mid-frame reset
    drv();
    send(8'h5A);
    send(8'h3C);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (m_in && m_k == 17) reached = 1'b1;
      else drv();
    end
    chk("rst_reach_bit5", 32'(reached), 32'd1);
    n_rst = 1'b0;
    drv();
    n_rst = 1'b1;
    obs();
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    c_a = 0; c_b = 0;
    repeat (50) begin
      obs();
      c_a += int'(frame_done);
      c_b += int'(load_enable);
    end
    chk("rst_no_done", 32'(c_a), 32'd0);
    chk("rst_buf_lost", 32'(c_b), 32'd0);
    drv();
    send(8'hC3);
    wait_load("rst_new_load", 10);
    chk("rst_new_image", 32'(parallel_in), 32'h30D);
    c_a = 0;
    repeat (FB * CPB + 4) begin
      obs();
      c_a += int'(frame_done);
    end
    chk("rst_new_done", 32'(c_a), 32'd1);

    drv();
    repeat (4) obs();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
